// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-stream byte to UART serialiser (start, 8 data LSB first, stop bits).
// Optional parity bit between data and stop is compiled in with AXIS_UART_TX_PARITY_EN.
module axis_uart_tx #(
  parameter int DIVIDER    = 104,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic       txd,
  output logic       busy
);
  localparam int BW = $clog2(DIVIDER);
  localparam logic [BW-1:0] RELOAD = BW'(DIVIDER - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
`ifdef AXIS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [7:0] data_q, data_d;
  logic iready_q, iready_d, txd_q, txd_d, busy_q, busy_d, last;
  assign last = baud_q == '0;
  always_comb begin
    state_d  = state_q;
    baud_d   = last ? RELOAD : baud_q - 1'b1;
    bit_d    = bit_q;
    stop_d   = state_q == STOP ? stop_q : 1'b0;
    data_d   = data_q;
    iready_d = iready_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        iready_d = 1'b1;
        baud_d   = '0;
        if (ivalid && iready_q) begin
          data_d   = idata;
          iready_d = 1'b0;
          busy_d   = 1'b1;
          baud_d   = RELOAD;
          state_d  = START;
        end
      end
      START: if (last) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (last) begin
        if (bit_q == 3'd7)
`ifdef AXIS_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        else
          bit_d = bit_q + 3'd1;
      end
`ifdef AXIS_UART_TX_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        if (stop_q == STOP_LAST) begin
          state_d  = IDLE;
          iready_d = 1'b1;
          busy_d   = 1'b0;
          baud_d   = '0;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is derived from the next state so txd is a plain register.
`ifdef AXIS_UART_TX_PARITY_EN
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[bit_d] :
            state_d == PARITY ? (^data_q) ^ PARITY_ODD : 1'b1;
`else
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[bit_d] : 1'b1;
`endif
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      iready_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      iready_q <= iready_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end
  assign iready = iready_q;
  assign txd    = txd_q;
  assign busy   = busy_q;
endmodule
